// File: rtl/cook_timer_ctrl.sv
// Microwave cook controller: one-hot keypad entry into a BCD M:SS register,
// countdown with pause/resume, duty-cycled magnetron enable and a timed
// done indication. Digits are stored as ones, tens, then minutes upward.
module cook_timer_ctrl #(
  parameter int TICKS_PER_SEC = 100,
  parameter int MIN_DIGITS    = 1,
  parameter int DUTY_STEPS    = 10,
  parameter int DONE_SECS     = 3
) (
  input  logic                    clk,
  input  logic                    clearn,
  input  logic [9:0]              keypad,
  input  logic                    startn,
  input  logic                    stopn,
  input  logic                    door_closed,
  input  logic [3:0]              power_level,
  output logic [3:0]              seconds_ones,
  output logic [3:0]              seconds_tens,
  output logic [4*MIN_DIGITS-1:0] minutes,
  output logic                    mag_on,
  output logic                    done,
  output logic [1:0]              state
);

  localparam int NUM_DIGITS = MIN_DIGITS + 2;
  localparam int PRE_W      = $clog2(TICKS_PER_SEC);
  localparam int DONE_W     = (DONE_SECS > 1) ? $clog2(DONE_SECS) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [DONE_W-1:0] DONE_LAST = DONE_W'(DONE_SECS - 1);
  localparam logic [3:0]        DUTY_MAX  = 4'(DUTY_STEPS);
  localparam logic [3:0]        DUTY_LAST = 4'(DUTY_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q;
  logic [3:0]          digits_q [NUM_DIGITS];
  logic [PRE_W-1:0]    prescaler_q;
  logic [3:0]          duty_q;
  logic [3:0]          power_q;
  logic [DONE_W-1:0]   doneCnt_q;
  logic                done_q;

  // Edge-detect history. armed_q blocks events on the first cycle after
  // reset so that a button held through reset release needs a fresh press.
  logic                armed_q;
  logic                keyZero_q;
  logic                startPrev_q;
  logic                stopPrev_q;

  logic                keyOneHot;
  logic                keyEvent;
  logic                startEvent;
  logic                stopEvent;
  logic [3:0]          keyDigit;
  logic [3:0]          effPower;
  logic                secTick;
  logic                timeNonZero;
  logic [3:0]          decDigits [NUM_DIGITS];
  logic                decZero;
  logic                borrow;

  // Single-cycle event pulses from the keypad and the two buttons.
  always_comb begin
    keyOneHot  = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);
    keyEvent   = armed_q && keyOneHot && keyZero_q;
    startEvent = armed_q && startPrev_q && !startn;
    stopEvent  = armed_q && stopPrev_q && !stopn;
  end

  // Encode the one-hot key into its digit value.
  always_comb begin
    keyDigit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (keypad[i]) begin
        keyDigit = 4'(i);
      end
    end
  end

  // Out-of-range or zero power means full power for the whole window.
  always_comb begin
    if ((power_level == 4'd0) || (power_level > DUTY_MAX)) begin
      effPower = DUTY_MAX;
    end else begin
      effPower = power_level;
    end
  end

  // One-second boundary of the prescaler, and whether any time is loaded.
  always_comb begin
    secTick     = (prescaler_q == PRE_LAST);
    timeNonZero = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digits_q[i] != 4'd0) begin
        timeNonZero = 1'b1;
      end
    end
  end

  // BCD one-second decrement; seconds borrow from minutes as 59, minutes
  // borrow between themselves as 9.
  always_comb begin
    borrow = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      decDigits[i] = digits_q[i];
    end
    if (digits_q[0] != 4'd0) begin
      decDigits[0] = digits_q[0] - 4'd1;
    end else if (digits_q[1] != 4'd0) begin
      decDigits[1] = digits_q[1] - 4'd1;
      decDigits[0] = 4'd9;
    end else begin
      decDigits[0] = 4'd9;
      decDigits[1] = 4'd5;
      borrow       = 1'b1;
      for (int i = 2; i < NUM_DIGITS; i++) begin
        if (borrow) begin
          if (digits_q[i] != 4'd0) begin
            decDigits[i] = digits_q[i] - 4'd1;
            borrow       = 1'b0;
          end else begin
            decDigits[i] = 4'd9;
          end
        end
      end
    end
    decZero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (decDigits[i] != 4'd0) begin
        decZero = 1'b0;
      end
    end
  end

  // Main controller: edge history, digit register, prescaler, duty window
  // and the IDLE/COOK/PAUSE/DONE sequencing.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digits_q[i] <= 4'd0;
      end
      prescaler_q <= '0;
      duty_q      <= 4'd0;
      power_q     <= 4'd0;
      doneCnt_q   <= '0;
      done_q      <= 1'b0;
      armed_q     <= 1'b0;
      keyZero_q   <= 1'b1;
      startPrev_q <= 1'b1;
      stopPrev_q  <= 1'b1;
    end else begin
      armed_q     <= 1'b1;
      keyZero_q   <= (keypad == 10'd0);
      startPrev_q <= startn;
      stopPrev_q  <= stopn;

      case (state_q)
        ST_IDLE: begin
          if (stopEvent) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              digits_q[i] <= 4'd0;
            end
          end else if (startEvent && door_closed && timeNonZero) begin
            state_q     <= ST_COOK;
            power_q     <= effPower;
            prescaler_q <= '0;
            duty_q      <= 4'd0;
          end else if (keyEvent) begin
            digits_q[0] <= keyDigit;
            for (int i = 1; i < NUM_DIGITS; i++) begin
              digits_q[i] <= digits_q[i-1];
            end
          end
        end

        ST_COOK: begin
          if (!door_closed || stopEvent) begin
            state_q <= ST_PAUSE;
          end else if (secTick) begin
            prescaler_q <= '0;
            duty_q      <= (duty_q == DUTY_LAST) ? 4'd0 : duty_q + 4'd1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
              digits_q[i] <= decDigits[i];
            end
            if (decZero) begin
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              doneCnt_q <= '0;
            end
          end else begin
            prescaler_q <= prescaler_q + PRE_W'(1);
          end
        end

        ST_PAUSE: begin
          if (stopEvent) begin
            state_q     <= ST_IDLE;
            prescaler_q <= '0;
            duty_q      <= 4'd0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
              digits_q[i] <= 4'd0;
            end
          end else if (startEvent && door_closed) begin
            state_q <= ST_COOK;
            power_q <= effPower;
          end
        end

        ST_DONE: begin
          if (keyEvent || startEvent || stopEvent) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            prescaler_q <= '0;
          end else if (secTick) begin
            prescaler_q <= '0;
            if (doneCnt_q == DONE_LAST) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b0;
            end else begin
              doneCnt_q <= doneCnt_q + DONE_W'(1);
            end
          end else begin
            prescaler_q <= prescaler_q + PRE_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Magnetron gating stays combinational on the door so it drops instantly.
  always_comb begin
    mag_on = (state_q == ST_COOK) && door_closed && (duty_q < power_q);
  end

  // Present the digit register as BCD outputs, top minute digit highest.
  always_comb begin
    seconds_ones = digits_q[0];
    seconds_tens = digits_q[1];
    minutes      = '0;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      minutes[4*i +: 4] = digits_q[2+i];
    end
    done  = done_q;
    state = state_q;
  end

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Bench for cook_timer_ctrl: a table of directed vectors for entry and a
// full cook cycle, followed by hand-written multi-cycle sequences.
module tb_cook_timer_ctrl;

  logic       clk;
  logic       clearn;
  logic [9:0] keypad;
  logic       startn;
  logic       stopn;
  logic       door_closed;
  logic [3:0] power_level;
  logic [3:0] seconds_ones;
  logic [3:0] seconds_tens;
  logic [3:0] minutes;
  logic       mag_on;
  logic       done;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0] kp;
    logic       st;
    logic       sp;
    logic       door;
    logic [3:0] pw;
    int         cycles;
    logic [1:0] expState;
    logic [3:0] expMin;
    logic [3:0] expTens;
    logic [3:0] expOnes;
    logic       expMag;
    logic       expDone;
    string      name;
  } vec_t;

  vec_t vecs[$];

  cook_timer_ctrl #(
    .TICKS_PER_SEC(100),
    .MIN_DIGITS(1),
    .DUTY_STEPS(10),
    .DONE_SECS(3)
  ) dut (
    .clk(clk),
    .clearn(clearn),
    .keypad(keypad),
    .startn(startn),
    .stopn(stopn),
    .door_closed(door_closed),
    .power_level(power_level),
    .seconds_ones(seconds_ones),
    .seconds_tens(seconds_tens),
    .minutes(minutes),
    .mag_on(mag_on),
    .done(done),
    .state(state)
  );

  // 10 ns clock; stimulus and sampling both happen on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [1:0] eState,
                             input logic [3:0] eMin, input logic [3:0] eTens,
                             input logic [3:0] eOnes, input logic eMag,
                             input logic eDone);
    checks++;
    if ({state, minutes, seconds_tens, seconds_ones, mag_on, done} !==
        {eState, eMin, eTens, eOnes, eMag, eDone}) begin
      errors++;
      $display("[TB] FAIL %s: got st=%0d %0d:%0d%0d mag=%0b done=%0b, want st=%0d %0d:%0d%0d mag=%0b done=%0b",
               name, state, minutes, seconds_tens, seconds_ones, mag_on, done,
               eState, eMin, eTens, eOnes, eMag, eDone);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    keypad      = v.kp;
    startn      = v.st;
    stopn       = v.sp;
    door_closed = v.door;
    power_level = v.pw;
    run(v.cycles);
    checkOutput(v.name, v.expState, v.expMin, v.expTens, v.expOnes,
                v.expMag, v.expDone);
  endtask

  task automatic doReset();
    clearn      = 1'b0;
    keypad      = '0;
    startn      = 1'b1;
    stopn       = 1'b1;
    door_closed = 1'b1;
    power_level = 4'd0;
    run(2);
    clearn = 1'b1;
    run(2);
  endtask

  task automatic pressKey(input int d);
    keypad    = '0;
    keypad[d] = 1'b1;
    run(2);
    keypad = '0;
    run(2);
  endtask

  task automatic pulseStart();
    startn = 1'b0;
    run(1);
    startn = 1'b1;
  endtask

  initial begin
    clearn      = 1'b0;
    keypad      = '0;
    startn      = 1'b1;
    stopn       = 1'b1;
    door_closed = 1'b1;
    power_level = 4'd0;
    #1;
    checkOutput("reset", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    run(2);
    clearn = 1'b1;
    run(2);

    // Entry, ignored start with door open, then a full 0:23 cook and done.
    vecs.push_back('{10'h004, 1'b1, 1'b1, 1'b1, 4'd0, 1,    2'd0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0, "key2"});
    vecs.push_back('{10'h004, 1'b1, 1'b1, 1'b1, 4'd0, 109,  2'd0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0, "key2held"});
    vecs.push_back('{10'h000, 1'b1, 1'b1, 1'b1, 4'd0, 1,    2'd0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0, "release2"});
    vecs.push_back('{10'h008, 1'b1, 1'b1, 1'b1, 4'd0, 1,    2'd0, 4'd0, 4'd2, 4'd3, 1'b0, 1'b0, "key3"});
    vecs.push_back('{10'h000, 1'b1, 1'b1, 1'b1, 4'd0, 1,    2'd0, 4'd0, 4'd2, 4'd3, 1'b0, 1'b0, "release3"});
    vecs.push_back('{10'h006, 1'b1, 1'b1, 1'b1, 4'd0, 1,    2'd0, 4'd0, 4'd2, 4'd3, 1'b0, 1'b0, "multiKey"});
    vecs.push_back('{10'h002, 1'b1, 1'b1, 1'b1, 4'd0, 1,    2'd0, 4'd0, 4'd2, 4'd3, 1'b0, 1'b0, "fromMulti"});
    vecs.push_back('{10'h000, 1'b1, 1'b1, 1'b1, 4'd0, 1,    2'd0, 4'd0, 4'd2, 4'd3, 1'b0, 1'b0, "releaseAll"});
    vecs.push_back('{10'h000, 1'b0, 1'b1, 1'b0, 4'd0, 1,    2'd0, 4'd0, 4'd2, 4'd3, 1'b0, 1'b0, "startDoorOpen"});
    vecs.push_back('{10'h000, 1'b1, 1'b1, 1'b0, 4'd0, 1,    2'd0, 4'd0, 4'd2, 4'd3, 1'b0, 1'b0, "releaseStart"});
    vecs.push_back('{10'h000, 1'b1, 1'b1, 1'b1, 4'd0, 1,    2'd0, 4'd0, 4'd2, 4'd3, 1'b0, 1'b0, "closeDoor"});
    vecs.push_back('{10'h000, 1'b0, 1'b1, 1'b1, 4'd0, 1,    2'd1, 4'd0, 4'd2, 4'd3, 1'b1, 1'b0, "start"});
    vecs.push_back('{10'h000, 1'b1, 1'b1, 1'b1, 4'd0, 99,   2'd1, 4'd0, 4'd2, 4'd3, 1'b1, 1'b0, "preTick"});
    vecs.push_back('{10'h000, 1'b1, 1'b1, 1'b1, 4'd0, 1,    2'd1, 4'd0, 4'd2, 4'd2, 1'b1, 1'b0, "firstTick"});
    vecs.push_back('{10'h000, 1'b1, 1'b1, 1'b1, 4'd0, 2199, 2'd1, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, "lastSec"});
    vecs.push_back('{10'h000, 1'b1, 1'b1, 1'b1, 4'd0, 1,    2'd3, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, "doneEntry"});
    vecs.push_back('{10'h000, 1'b1, 1'b1, 1'b1, 4'd0, 299,  2'd3, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, "doneHold"});
    vecs.push_back('{10'h000, 1'b1, 1'b1, 1'b1, 4'd0, 1,    2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "doneExpire"});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Four keys into a single minute digit drop the oldest one.
    doReset();
    pressKey(1);
    pressKey(2);
    pressKey(3);
    pressKey(4);
    checkOutput("entry1234", 2'd0, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0);

    // Simultaneous start and stop in IDLE: stop clears.
    startn = 1'b0;
    stopn  = 1'b0;
    run(1);
    checkOutput("startStopIdle", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    startn = 1'b1;
    stopn  = 1'b1;
    run(1);

    // Minute borrow: 1:00 -> 0:59 -> 0:58.
    doReset();
    pressKey(1);
    pressKey(0);
    pressKey(0);
    checkOutput("entry100", 2'd0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
    pulseStart();
    run(100);
    checkOutput("borrow059", 2'd1, 4'd0, 4'd5, 4'd9, 1'b1, 1'b0);
    run(100);
    checkOutput("borrow058", 2'd1, 4'd0, 4'd5, 4'd8, 1'b1, 1'b0);

    // Pause after 10 s, resume, and finish exactly 13 s after resume.
    doReset();
    pressKey(2);
    pressKey(3);
    pulseStart();
    run(1000);
    checkOutput("cook10s", 2'd1, 4'd0, 4'd1, 4'd3, 1'b1, 1'b0);
    stopn = 1'b0;
    run(1);
    checkOutput("pause", 2'd2, 4'd0, 4'd1, 4'd3, 1'b0, 1'b0);
    stopn = 1'b1;
    pressKey(8);
    run(50);
    checkOutput("pauseFrozen", 2'd2, 4'd0, 4'd1, 4'd3, 1'b0, 1'b0);
    pulseStart();
    checkOutput("resume", 2'd1, 4'd0, 4'd1, 4'd3, 1'b1, 1'b0);
    run(1299);
    checkOutput("resumeLast", 2'd1, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
    run(1);
    checkOutput("resumeDone", 2'd3, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);

    // A key in DONE returns to IDLE without being entered.
    keypad    = '0;
    keypad[7] = 1'b1;
    run(1);
    checkOutput("doneKeyExit", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    keypad = '0;
    run(2);

    // Stop twice from COOK clears back to IDLE.
    doReset();
    pressKey(5);
    pulseStart();
    run(10);
    stopn = 1'b0;
    run(1);
    checkOutput("stopOnce", 2'd2, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0);
    stopn = 1'b1;
    run(1);
    stopn = 1'b0;
    run(1);
    checkOutput("stopTwice", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    stopn = 1'b1;
    run(1);

    // Power 3 of 10: on for seconds 0-2 and 10-12, then door opens.
    doReset();
    power_level = 4'd3;
    pressKey(2);
    pressKey(0);
    pulseStart();
    run(49);
    checkOutput("duty sec0", 2'd1, 4'd0, 4'd2, 4'd0, 1'b1, 1'b0);
    run(200);
    checkOutput("duty sec2", 2'd1, 4'd0, 4'd1, 4'd8, 1'b1, 1'b0);
    run(100);
    checkOutput("duty sec3", 2'd1, 4'd0, 4'd1, 4'd7, 1'b0, 1'b0);
    run(600);
    checkOutput("duty sec9", 2'd1, 4'd0, 4'd1, 4'd1, 1'b0, 1'b0);
    run(100);
    checkOutput("duty sec10", 2'd1, 4'd0, 4'd1, 4'd0, 1'b1, 1'b0);
    run(150);
    checkOutput("duty sec11", 2'd1, 4'd0, 4'd0, 4'd9, 1'b1, 1'b0);
    door_closed = 1'b0;
    #1;
    checkOutput("doorOpenComb", 2'd1, 4'd0, 4'd0, 4'd9, 1'b0, 1'b0);
    run(1);
    checkOutput("doorOpenPause", 2'd2, 4'd0, 4'd0, 4'd9, 1'b0, 1'b0);
    door_closed = 1'b1;
    power_level = 4'd0;

    // Reset mid-cook with start held low across release.
    doReset();
    pressKey(9);
    pulseStart();
    run(20);
    clearn = 1'b0;
    startn = 1'b0;
    #1;
    checkOutput("asyncReset", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    run(3);
    clearn = 1'b1;
    run(5);
    checkOutput("heldStart", 2'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    pressKey(4);
    checkOutput("heldStartKey", 2'd0, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0);
    startn = 1'b1;
    run(1);
    pulseStart();
    checkOutput("freshStart", 2'd1, 4'd0, 4'd0, 4'd4, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cook_timer_ctrl.md
# cook_timer_ctrl

Parametrised microwave cook controller: takes one-hot keypad digits, start/stop/door inputs, and runs an M:SS countdown while driving the magnetron enable. It adds the following to the first-generation controller: configurable tick rate and minute-digit count, pause/resume, a duty-cycled power level, and a timed done indication. Outputs are BCD; 7-segment decode lives downstream.

## Interface
- TICKS_PER_SEC, 100: clk cycles per countdown second (≥2).
- MIN_DIGITS, 1: BCD minute digits (1..2).
- DUTY_STEPS, 10: seconds per power-duty window (2..15).
- DONE_SECS, 3: seconds `done` stays high after completion (≥1).
- clk  in  1  system clock; all logic on rising edge.
- clearn  in  1  asynchronous, active-low reset.
- keypad  in  10  one-hot digit keys; bit i = digit i.
- startn  in  1  start/resume button, active-low level.
- stopn  in  1  stop/pause/clear button, active-low level.
- door_closed  in  1  1 = door closed.
- power_level  in  4  on-seconds per duty window; 0 or >DUTY_STEPS means DUTY_STEPS.
- seconds_ones  out  4  BCD seconds units.
- seconds_tens  out  4  BCD seconds tens.
- minutes  out  4*MIN_DIGITS  BCD minutes, most significant digit at the top.
- mag_on  out  1  magnetron enable.
- done  out  1  cook-complete indication.
- state  out  2  0 IDLE, 1 COOK, 2 PAUSE, 3 DONE.

## Operation
- Reset (clearn=0, async): all digits 0, state IDLE, prescaler/duty index 0, mag_on 0, done 0, edge-detect history = released.
- Edge detection, synchronous, one cycle each:
  - key event = keypad one-hot this cycle AND keypad==0 last cycle.
  - start event = startn falling edge.
  - stop event = stopn falling edge.
  - Non-one-hot keypad patterns are ignored; no event fires until keypad returns to 0.
- IDLE:
  - Key event shifts the digit in: new → ones, ones → tens, tens → minutes LSD, and so on upward. The top minutes digit is discarded.
  - Tens digits above 5 are accepted as entered.
  - Stop event clears all digits.
  - Start event with door_closed=1 and nonzero time → COOK. It latches the effective power level, prescaler=0, duty index=0.
  - Start event with zero time or door open is ignored.
- COOK:
  - Priority: door open > stop > tick.
  - door_closed=0 → PAUSE.
  - Stop event → PAUSE.
  - Key events are ignored.
  - Prescaler counts 0..TICKS_PER_SEC-1. At terminal count it decrements the time by one second and advances the duty index modulo DUTY_STEPS.
- Decrement (BCD):
  - If ones≠0, decrement ones.
  - Else if tens≠0, decrement tens and set ones=9.
  - Else borrow from minutes (BCD decrement across minute digits), tens=5, ones=9.
  - If the result is all-zero → DONE, prescaler=0.
- PAUSE:
  - Time, prescaler and duty index are frozen.
  - Start event with door_closed=1 → COOK. This re-latches power_level; prescaler and duty index resume unchanged.
  - Stop event → IDLE with digits cleared.
  - Key events are ignored.
- DONE:
  - done=1; the prescaler runs.
  - After DONE_SECS seconds → IDLE with done=0.
  - Any key, start or stop event → IDLE immediately. That key is not entered.
- mag_on = (state==COOK) & door_closed & (duty_index < latched power). This is combinational, so a door opening drops mag_on in the same cycle.

## Timing
- Entry: digits update on the clock edge following the keypad 0→one-hot transition (1-cycle latency).
- Start: state=COOK and mag_on=1 on the edge after startn falls (door closed, power>0).
- First decrement occurs TICKS_PER_SEC cycles after entering COOK. Subsequent decrements occur every TICKS_PER_SEC cycles of COOK.
- Pause/resume preserves the partial second exactly: the total cook cycles equal the programmed seconds × TICKS_PER_SEC.
- DONE lasts exactly DONE_SECS×TICKS_PER_SEC cycles, absent events.
- Simultaneous start and stop events: stop wins in every state.
- Reset mid-operation: outputs go to reset values asynchronously. The first event is accepted only after a fresh edge following reset release.

## Test plan
- Reset, press 2 then 3 (1.1 s each, with 0 between) → minutes=0, tens=2, ones=3, state=0. Pressing 1,2,3,4 with MIN_DIGITS=1 → 2:34.
- 0:23, door open, start → still IDLE, mag_on=0. Close door, start → state=1, mag_on=1 next cycle. 23×100 cycles later → state=3, done=1, mag_on=0. 300 cycles later → IDLE, done=0.
- 1:00 start → after 100 cycles display 0:59, then 0:58 after 100 more.
- 0:23 cooking, stop after 10 s → PAUSE at 0:13, mag_on=0, digits frozen. Start → resumes, done at 13 s later. Stop twice from COOK → IDLE, 0:00.
- power_level=3, DUTY_STEPS=10, 0:20 → mag_on high for seconds 0–2 and 10–12, low otherwise. Opening the door mid-cook → mag_on low the same cycle, state=2 next edge.
- clearn pulsed low for 1 ms during COOK → all outputs 0 immediately. startn held low across release → no start until a new falling edge.
